// File: rtl/sram_arbiter.sv
// Request/acknowledge arbiter sharing one 64Kx8 SRAM between the AVR host port and the Coco bus.
// Owns every SRAM control pin; each transaction runs IDLE -> ACCESS (N ticks) -> DONE -> IDLE.
module sram_arbiter #(
    parameter int unsigned AVR_TICKS     = 4,
    parameter int unsigned COCO_RD_TICKS = 6,
    parameter int unsigned COCO_WR_TICKS = 4,
    parameter int unsigned STARVE_LIMIT  = 3
) (
    input  logic        clock_50,
    input  logic        c_reset_n,

    input  logic        avr_req,
    input  logic        avr_rw,
    input  logic [15:0] avr_addr,
    input  logic [7:0]  avr_wdata,
    output logic        avr_ack,
    output logic [7:0]  avr_rdata,

    input  logic        coco_req,
    input  logic        coco_rw,
    input  logic [15:0] coco_addr,
    input  logic [7:0]  coco_wdata,
    output logic        coco_ack,
    output logic [7:0]  coco_rdata,

    output logic [15:0] sram_addrbus,
    output logic [7:0]  sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n,

    output logic        busy
);

    if (AVR_TICKS < 2 || AVR_TICKS > 15) begin : g_bad_avr_ticks
        $error("AVR_TICKS must be in 2..15");
    end
    if (COCO_RD_TICKS < 2 || COCO_RD_TICKS > 15) begin : g_bad_coco_rd_ticks
        $error("COCO_RD_TICKS must be in 2..15");
    end
    if (COCO_WR_TICKS < 2 || COCO_WR_TICKS > 15) begin : g_bad_coco_wr_ticks
        $error("COCO_WR_TICKS must be in 2..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..7");
    end

    localparam logic [3:0] AVR_N     = 4'(AVR_TICKS);
    localparam logic [3:0] COCO_RD_N = 4'(COCO_RD_TICKS);
    localparam logic [3:0] COCO_WR_N = 4'(COCO_WR_TICKS);
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [3:0]  r_cnt;
    logic [2:0]  r_starve;
    logic        r_sel_coco;
    logic        r_rw;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_avr_rdata;
    logic [7:0]  r_coco_rdata;

    logic        w_any_req;
    logic        w_grant;
    logic        w_sel_coco;
    logic        w_req_rw;
    logic [15:0] w_req_addr;
    logic [7:0]  w_req_wdata;
    logic [3:0]  w_req_ticks;
    logic        w_last;

    assign w_any_req = avr_req | coco_req;
    assign w_grant   = (r_state == StIdle) && w_any_req;
    assign w_last    = (r_cnt == 4'd1);

    // AVR has priority unless Coco has already been passed over STARVE_LIMIT times in a row
    assign w_sel_coco  = coco_req && (!avr_req || (r_starve == STARVE_MAX));
    assign w_req_rw    = w_sel_coco ? coco_rw    : avr_rw;
    assign w_req_addr  = w_sel_coco ? coco_addr  : avr_addr;
    assign w_req_wdata = w_sel_coco ? coco_wdata : avr_wdata;
    assign w_req_ticks = w_sel_coco ? (coco_rw ? COCO_RD_N : COCO_WR_N) : AVR_N;

    // State register
    always_ff @(posedge clock_50 or negedge c_reset_n) begin
        if (!c_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_any_req) w_state_next = StAccess;
            StAccess: if (w_last)    w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Operands are latched only on the grant edge and held for the whole transaction
    always_ff @(posedge clock_50 or negedge c_reset_n) begin
        if (!c_reset_n) begin
            r_sel_coco <= 1'b0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_grant) begin
            r_sel_coco <= w_sel_coco;
            r_rw       <= w_req_rw;
            r_addr     <= w_req_addr;
            r_wdata    <= w_req_wdata;
        end
    end

    always_ff @(posedge clock_50 or negedge c_reset_n) begin
        if (!c_reset_n) begin
            r_cnt <= '0;
        end else if (w_grant) begin
            r_cnt <= w_req_ticks;
        end else if (r_state == StAccess && !w_last) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clock_50 or negedge c_reset_n) begin
        if (!c_reset_n) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (w_sel_coco) begin
                r_starve <= '0;
            end else if (coco_req && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end

    // Read data is captured on the last ACCESS edge while OE is still asserted
    always_ff @(posedge clock_50 or negedge c_reset_n) begin
        if (!c_reset_n) begin
            r_avr_rdata  <= '0;
            r_coco_rdata <= '0;
        end else if (r_state == StAccess && w_last && r_rw) begin
            if (r_sel_coco) begin
                r_coco_rdata <= sram_dq_in;
            end else begin
                r_avr_rdata <= sram_dq_in;
            end
        end
    end

    // Output logic
    always_comb begin
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_dq_oe = 1'b0;
        avr_ack    = 1'b0;
        coco_ack   = 1'b0;
        unique case (r_state)
            StAccess: begin
                if (r_rw) begin
                    sram_oe_n = 1'b0;
                end else begin
                    sram_dq_oe = 1'b1;
                    // Release WE one tick early so address and data are held past its rising edge
                    sram_we_n  = w_last;
                end
            end
            StDone: begin
                if (r_sel_coco) begin
                    coco_ack = 1'b1;
                end else begin
                    avr_ack = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy         = (r_state != StIdle);
    assign sram_addrbus = r_addr;
    assign sram_dq_out  = r_wdata;
    assign avr_rdata    = r_avr_rdata;
    assign coco_rdata   = r_coco_rdata;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences and shares the single 64Kx8 disk-buffer SRAM between two requesters: the AVR host port and the Coco bus side (SCS register window and CTS ROM window).
- Replaces ad-hoc counter/request-flag sequencing with one request/acknowledge arbiter that owns all SRAM control pins.
- Sits between the bus-edge synchronisers and the SRAM pins. The top level builds the bidirectional data pad from the split dq signals.

Parameters:
- AVR_TICKS, 4, ACCESS-state cycle count for any AVR read or write (legal 2..15).
- COCO_RD_TICKS, 6, ACCESS-state cycle count for a Coco read (legal 2..15).
- COCO_WR_TICKS, 4, ACCESS-state cycle count for a Coco write (legal 2..15).
- STARVE_LIMIT, 3, maximum consecutive AVR grants while a Coco request is waiting (legal 1..7).

Ports:
- clock_50  in  1  system clock, 50 MHz.
- c_reset_n  in  1  asynchronous active-low reset.
- avr_req  in  1  AVR request level, held until avr_ack.
- avr_rw  in  1  1=read, 0=write.
- avr_addr  in  16  AVR SRAM address.
- avr_wdata  in  8  AVR write data.
- avr_ack  out  1  one-cycle completion pulse.
- avr_rdata  out  8  AVR read data.
- coco_req  in  1  Coco request level, held until coco_ack.
- coco_rw  in  1  1=read, 0=write.
- coco_addr  in  16  Coco SRAM address, already mapped by the requester.
- coco_wdata  in  8  Coco write data.
- coco_ack  out  1  one-cycle completion pulse.
- coco_rdata  out  8  Coco read data.
- sram_addrbus  out  16  SRAM address.
- sram_dq_out  out  8  SRAM write data.
- sram_dq_oe  out  1  1=drive SRAM data pins.
- sram_dq_in  in  8  SRAM read data.
- sram_we_n  out  1  SRAM write enable.
- sram_oe_n  out  1  SRAM output enable.
- busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Interface: one clock, clock_50. Reset c_reset_n is asynchronous, active-low.
- Reset values:
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
  - sram_addrbus=0, sram_dq_out=0.
  - avr_ack=0, coco_ack=0, avr_rdata=0, coco_rdata=0.
  - busy=0, state=IDLE, starve count=0.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE, no request pending: hold all SRAM controls inactive.
- IDLE, request pending:
  - Select the winner.
  - Latch the winner's addr, rw and wdata into sram_addrbus and sram_dq_out on the same edge.
  - Load the tick counter with the winner's tick count N.
  - Enter ACCESS.
- Priority:
  - If only one port requests, that port wins.
  - If both request, AVR wins, unless starve count equals STARVE_LIMIT; then Coco wins.
- Starve count:
  - Increments on each AVR grant made while coco_req=1; saturates at STARVE_LIMIT.
  - Clears on every Coco grant.
- ACCESS, read:
  - sram_oe_n=0, sram_we_n=1, sram_dq_oe=0 for all N cycles.
  - On the last ACCESS edge, sram_dq_in is captured into the winner's rdata register.
- ACCESS, write:
  - sram_dq_oe=1 and sram_oe_n=1 for all N cycles.
  - sram_we_n=0 for the first N-1 cycles and 1 on the last cycle, giving one cycle of address/data hold.
- DONE:
  - All SRAM controls inactive; the winner's ack=1 for exactly this cycle; then IDLE.
  - The rdata register holds its value until that port's next read completes.
- Latency: ack is asserted N+1 cycles after the IDLE edge that sampled the request.
- Requester rule:
  - A registered requester drops req on the edge where it samples ack, so the following IDLE cycle never re-grants a stale request.
  - A new request may be raised on the cycle after ack.
- Latched operands:
  - Request inputs are ignored outside IDLE. The latched addr, rw and wdata are used for the whole transaction.
  - Changing a requester's operands mid-transaction has no effect on that transaction.
- Tick counter: 4 bits, counts down to 1, no wrap.
- Tick parameters outside 2..15 are an elaboration error.
- Reset asserted mid-transaction:
  - Outputs return to reset values immediately, including sram_we_n=1; no ack is issued.
  - After reset release, the arbiter is in IDLE.

Test Plan:
- Reset with avr_req=1, avr_rw=0, avr_addr=16'h1234, avr_wdata=8'hA5 held -> all outputs at reset values. After release: sram_addrbus=16'h1234; sram_we_n low for 3 cycles then high for 1; avr_ack pulses 5 cycles after the grant edge; busy high for 5 cycles.
- Pre-load SRAM model addr 16'h8010=8'h3C; coco_req read of 16'h8010 -> sram_oe_n low for 6 cycles; coco_rdata=8'h3C from the cycle coco_ack pulses; coco_rdata holds through a later AVR write.
- avr_req and coco_req held continuously, with each requester re-requesting one cycle after its ack -> grant order AVR, AVR, AVR, COCO, AVR, ... with STARVE_LIMIT=3; coco_ack never lags more than 3 AVR transactions.
- Assert c_reset_n low during write ACCESS cycle 2 -> sram_we_n=1 asynchronously; no avr_ack; the first post-reset grant starts from IDLE.
- Change avr_addr and avr_wdata during an AVR write ACCESS -> sram_addrbus and sram_dq_out stay at the latched values until DONE.
- coco_req write with COCO_WR_TICKS=2 -> sram_we_n low for exactly 1 cycle; coco_ack 3 cycles after the grant edge.
